mmio_bridge: RTL
================

// Module: mmio_bridge
// PURPOSE
//  Parametrised CPU-to-device bridge between the M-stage data port and the
//  data memory, NUM_TC timer slots and the interrupt generator. Decodes the
//  address and gates write enables per device. Adds a one-wait-state
//  registered read path for timers, plus detection of unmapped and misaligned
//  accesses. Sits between the CPU core and the peripherals in the top level.
// PARAMETERS
//  NUM_TC     2         number of timer slots (1..8)
//  DM_LIMIT   32'h2fff  last DM byte address (DM base is 0)
//  TC_BASE    32'h7f00  base of timer slot 0
//  TC_STRIDE  32'h10    address stride between timer slots
//  TC_LAST    32'hb     last byte offset inside a slot (3 words: CTRL/PRESET/COUNT)
//  INT_BASE   32'h7f20  interrupt-generator word address (4 bytes)
// PORTS
//  clk           in   1          clock
//  reset         in   1          synchronous, active-high
//  cpu_addr      in   32         byte address from M stage
//  cpu_wdata     in   32         store data, already lane-aligned
//  cpu_byteen    in   4          store lane enables; 0 = no store
//  cpu_rd        in   1          load request this cycle
//  cpu_rdata     out  32         load data back to M stage
//  cpu_stall     out  1          hold M stage (timer load wait state)
//  cpu_err       out  1          access fault indication
//  err_addr      out  32         faulting address (see CONFIGURATION)
//  dm_addr       out  32         = cpu_addr
//  dm_wdata      out  32         = cpu_wdata
//  dm_byteen     out  4          cpu_byteen if DM hit, else 0
//  dm_rdata      in   32         DM read data (combinational)
//  tc_addr       out  32         = cpu_addr (shared by all timers)
//  tc_din        out  32         = cpu_wdata
//  tc_we         out  NUM_TC     one-hot write enable, bit i = slot i
//  tc_dout       in   32*NUM_TC  slot i at [32*i+31:32*i]
//  int_addr      out  32         = cpu_addr
//  int_byteen    out  4          cpu_byteen if INT hit, else 0
// BEHAVIOUR
//  Decode (inclusive): DM 0..DM_LIMIT; slot i TC_BASE+i*TC_STRIDE ..
//  +TC_LAST; INT INT_BASE..INT_BASE+3. Other addresses are unmapped.
//  Writes: never stall; the device enable is live in the same cycle.
//  tc_we[i] = slot-i hit & (cpu_byteen==4'hf) & addr[1:0]==0.
//  Faults: unmapped addr with cpu_rd or |cpu_byteen. Timer access with
//  addr[1:0]!=0. Timer store with cpu_byteen!=4'hf. A faulting access
//  writes nothing (all enables 0) and returns rdata 0.
//  DM load: 0 wait; cpu_rdata=dm_rdata combinationally, cpu_stall=0.
//  INT load: 0 wait; cpu_rdata=0.
//  FSM (2 states, reset -> IDLE):
//   IDLE: valid timer load (cpu_rd, slot i hit, aligned) -> cpu_stall=1;
//     rdata_q<=tc_dout[slot i] at the edge; go to RESP.
//   RESP: cpu_stall=0, cpu_rdata=rdata_q, unconditionally back to IDLE.
//     The CPU still presents the same load; it must not re-trigger.
//   A store presented in RESP is handled like a store in IDLE.
//  Load latency: DM/INT 0 cycles; timer 1 stall cycle.
//  Reset values: FSM=IDLE, rdata_q=0, cpu_stall=0, err flag=0, err_addr=0.
//  Reset mid-wait: FSM returns to IDLE and the pending load is dropped.
//  cpu_rd together with |cpu_byteen is illegal; the store wins, no stall.
// CONFIGURATION
//  MMIO_ERR_CAPTURE_EN defined: on the first fault, err_addr<=cpu_addr and a
//   sticky err flag sets. cpu_err=flag. Later faults do not overwrite
//   err_addr. Only reset clears flag and err_addr.
//  Undefined: cpu_err = combinational fault this cycle; err_addr tied 0;
//   no capture registers.
// TESTING
//  sw 0x1234 @0x0010 (byteen f) -> dm_byteen=f, tc_we=0, int_byteen=0, no stall
//  lw @0x7f18, tc_dout slot1=0xABCD -> stall 1 cycle, then cpu_rdata=0xABCD
//  sb @0x7f04 byteen=4'h1 -> tc_we=0, cpu_err=1 (EN: err_addr=0x7f04, sticky)
//  lw @0x5000 then lw @0x6000 -> rdata 0, err; EN: err_addr stays 0x5000
//  reset asserted during the timer wait cycle -> next cycle IDLE, stall=0, rdata_q=0
//  sw @0x7f20 byteen f -> int_byteen=f; lw @0x7f20 -> cpu_rdata=0, no stall

Source files
------------

// File: rtl/mmio_bridge.sv
// mmio_bridge
//   Bridge between the CPU M-stage data port and its devices: data memory
//   (DM), NUM_TC timer slots and the interrupt generator (INT). It decodes
//   the byte address, gates per-device write enables and flags faulting
//   accesses. Timer loads take one wait state through a registered read path.
//
//   Optional feature: define MMIO_ERR_CAPTURE_EN to latch the first faulting
//   address and hold a sticky error flag. When it is undefined, cpu_err is the
//   fault of the current cycle and err_addr is tied to zero.
//
//   Ports
//     clk, reset               clock, synchronous active-high reset
//     cpu_addr/wdata/byteen/rd M-stage request (byteen == 0 means no store)
//     cpu_rdata/stall/err      response, wait-state request, fault flag
//     err_addr                 captured fault address (capture build only)
//     dm_*                     data memory port, dm_rdata is combinational
//     tc_*                     shared timer port, one-hot tc_we, packed tc_dout
//     int_addr/int_byteen      interrupt generator write port
module mmio_bridge #(
    parameter int          NUM_TC    = 2,
    parameter logic [31:0] DM_LIMIT  = 32'h0000_2fff,
    parameter logic [31:0] TC_BASE   = 32'h0000_7f00,
    parameter logic [31:0] TC_STRIDE = 32'h0000_0010,
    parameter logic [31:0] TC_LAST   = 32'h0000_000b,
    parameter logic [31:0] INT_BASE  = 32'h0000_7f20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           cpu_addr,
    input  logic [31:0]           cpu_wdata,
    input  logic [3:0]            cpu_byteen,
    input  logic                  cpu_rd,
    output logic [31:0]           cpu_rdata,
    output logic                  cpu_stall,
    output logic                  cpu_err,
    output logic [31:0]           err_addr,
    output logic [31:0]           dm_addr,
    output logic [31:0]           dm_wdata,
    output logic [3:0]            dm_byteen,
    input  logic [31:0]           dm_rdata,
    output logic [31:0]           tc_addr,
    output logic [31:0]           tc_din,
    output logic [NUM_TC-1:0]     tc_we,
    input  logic [32*NUM_TC-1:0]  tc_dout,
    output logic [31:0]           int_addr,
    output logic [3:0]            int_byteen
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [31:0]        rdata_q;
    logic [NUM_TC-1:0]  tc_hit;
    logic [31:0]        tc_sel;
    logic               dm_hit;
    logic               int_hit;
    logic               tc_any;
    logic               unmapped;
    logic               is_store;
    logic               is_load;
    logic               aligned;
    logic               fault;
    logic               tc_load;

    // Timer slot decode; slots never overlap, so OR-ing the hit slot's data
    // gives a plain one-hot read mux.
    always_comb begin
        tc_hit = '0;
        tc_sel = 32'h0000_0000;
        for (int i = 0; i < NUM_TC; i++) begin
            if ((cpu_addr >= TC_BASE + 32'(i) * TC_STRIDE) &&
                (cpu_addr <= TC_BASE + 32'(i) * TC_STRIDE + TC_LAST)) begin
                tc_hit[i] = 1'b1;
                tc_sel    = tc_sel | tc_dout[32*i +: 32];
            end else begin
                tc_hit[i] = 1'b0;
            end
        end
    end

    assign dm_hit   = (cpu_addr <= DM_LIMIT);
    assign int_hit  = (cpu_addr >= INT_BASE) && (cpu_addr <= INT_BASE + 32'd3);
    assign tc_any   = |tc_hit;
    assign unmapped = ~(dm_hit | tc_any | int_hit);

    // A load presented together with a store is treated as the store.
    assign is_store = |cpu_byteen;
    assign is_load  = cpu_rd & ~is_store;
    assign aligned  = (cpu_addr[1:0] == 2'b00);

    // Timers only accept aligned full-word accesses.
    assign fault = (is_store | cpu_rd) &
                   (unmapped |
                    (tc_any & ~aligned) |
                    (tc_any & is_store & (cpu_byteen != 4'hf)));

    assign tc_load = is_load & tc_any & aligned;

    // Address/data fan out unchanged; only the enables are gated.
    assign dm_addr    = cpu_addr;
    assign dm_wdata   = cpu_wdata;
    assign tc_addr    = cpu_addr;
    assign tc_din     = cpu_wdata;
    assign int_addr   = cpu_addr;
    assign dm_byteen  = (dm_hit & ~fault) ? cpu_byteen : 4'h0;
    assign int_byteen = (int_hit & ~fault) ? cpu_byteen : 4'h0;
    assign tc_we      = (is_store & ~fault & aligned & (cpu_byteen == 4'hf)) ?
                        tc_hit : {NUM_TC{1'b0}};

    // Read-path FSM: next state, stall and load data mux.
    always_comb begin
        next_state = state;
        cpu_stall  = 1'b0;
        cpu_rdata  = 32'h0000_0000;
        case (state)
            IDLE: begin
                if (tc_load) begin
                    cpu_stall  = 1'b1;
                    next_state = RESP;
                end else if (is_load & dm_hit & ~fault) begin
                    cpu_rdata = dm_rdata;
                end else begin
                    cpu_rdata = 32'h0000_0000;
                end
            end
            RESP: begin
                // The CPU still shows the same load here; always leave RESP
                // so it is answered exactly once.
                next_state = IDLE;
                if (is_load & ~fault) begin
                    cpu_rdata = rdata_q;
                end else begin
                    cpu_rdata = 32'h0000_0000;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register and timer read-data capture during the wait state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            rdata_q <= 32'h0000_0000;
        end else begin
            state <= next_state;
            if ((state == IDLE) && tc_load) begin
                rdata_q <= tc_sel;
            end
        end
    end

`ifdef MMIO_ERR_CAPTURE_EN
    logic        err_flag;
    logic [31:0] err_addr_q;

    // Sticky capture of the first faulting address; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_flag   <= 1'b0;
            err_addr_q <= 32'h0000_0000;
        end else if (fault & ~err_flag) begin
            err_flag   <= 1'b1;
            err_addr_q <= cpu_addr;
        end
    end

    assign cpu_err  = err_flag;
    assign err_addr = err_addr_q;
`else
    assign cpu_err  = fault;
    assign err_addr = 32'h0000_0000;
`endif

endmodule
